// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  // Environment view: drives the instruction stream and downstream ready.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );

  // Decode stage view.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with output register plus one-entry skid buffer.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_stage_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  dec_t               dec;
  logic signed [31:0] imm32;
  logic [31:0]        ins;

  dec_t or_q, or_d, sr_q, sr_d;
  logic or_v_q, or_v_d, sr_v_q, sr_v_d, rdy_q, rdy_d;
  logic acc, drain;

  // Combinational field extraction, immediate generation and format class.
  always_comb begin
    ins         = bus.in_instr;
    imm32       = '0;
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.opcode  = ins[6:0];
    dec.rd      = ins[11:7];
    dec.rs1     = ins[19:15];
    dec.rs2     = ins[24:20];
    dec.funct3  = ins[14:12];
    dec.funct7  = ins[31:25];
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b1;
    if (ins[1:0] == 2'b11) begin
      dec.illegal = 1'b0;
      unique case (ins[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          dec.fmt = FMT_I;
          imm32   = {{20{ins[31]}}, ins[31:20]};
        end
        7'b0100011: begin
          dec.fmt = FMT_S;
          imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        end
        7'b1100011: begin
          dec.fmt = FMT_B;
          imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec.fmt = FMT_U;
          imm32   = {ins[31:12], 12'b0};
        end
        7'b1101111: begin
          dec.fmt = FMT_J;
          imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        7'b0110011: dec.fmt = FMT_R;
        default: begin
          dec.fmt     = FMT_ILL;
          dec.illegal = 1'b1;
        end
      endcase
    end
    // Signed source, so the widening cast sign-extends to XLEN.
    dec.imm = XLEN'(imm32);
  end

  assign acc   = bus.in_valid && rdy_q;
  assign drain = or_v_q && bus.out_ready;

  // Next-state routing between input, skid register and output register.
  always_comb begin
    or_d   = or_q;
    sr_d   = sr_q;
    or_v_d = or_v_q;
    sr_v_d = sr_v_q;
    if (flush) begin
      or_v_d = 1'b0;
      sr_v_d = 1'b0;
    end else if (!or_v_q || (drain && !sr_v_q)) begin
      or_v_d = acc;
      if (acc) or_d = dec;
    end else if (!drain) begin
      if (acc) begin
        sr_d   = dec;
        sr_v_d = 1'b1;
      end
    end else begin
      or_d   = sr_q;
      or_v_d = 1'b1;
      sr_v_d = acc;
      if (acc) sr_d = dec;
    end
    rdy_d = !sr_v_d;
  end

  // State registers; reset clears data so hidden outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_q   <= '0;
      sr_q   <= '0;
      or_v_q <= 1'b0;
      sr_v_q <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      or_q   <= or_d;
      sr_q   <= sr_d;
      or_v_q <= or_v_d;
      sr_v_q <= sr_v_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = or_v_q;
  assign bus.out_pc      = or_q.pc;
  assign bus.out_opcode  = or_q.opcode;
  assign bus.out_rd      = or_q.rd;
  assign bus.out_rs1     = or_q.rs1;
  assign bus.out_rs2     = or_q.rs2;
  assign bus.out_funct3  = or_q.funct3;
  assign bus.out_funct7  = or_q.funct7;
  assign bus.out_imm     = or_q.imm;
  assign bus.out_fmt     = or_q.fmt;
  assign bus.out_illegal = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32 and XLEN=64 copies).
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_W(32)) b32 ();
  decode_stage_if #(.XLEN(64), .PC_W(32)) b64 ();

  // The 64-bit copy sees exactly the same stimulus.
  assign b64.in_valid  = b32.in_valid;
  assign b64.in_instr  = b32.in_instr;
  assign b64.in_pc     = b32.in_pc;
  assign b64.out_ready = b32.out_ready;

  decode_stage #(.XLEN(32), .PC_W(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    b32.in_valid = v;
    b32.in_instr = instr;
    b32.in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    b32.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset values
    chk("rst_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_pc", 64'(b32.out_pc), 64'd0);
    chk("rst_fmt", 64'(b32.out_fmt), 64'd0);
    chk("rst_ill", 64'(b32.out_illegal), 64'd0);
    chk("rst_rd", 64'(b32.out_rd), 64'd0);
    rst = 1'b0;

    // lw x5,-4(x2): latency one edge
    drive(1'b1, 32'hFFC12283, 32'h100);
    tick();
    chk("lw_valid", 64'(b32.out_valid), 64'd1);
    chk("lw_fmt", 64'(b32.out_fmt), 64'd1);
    chk("lw_rd", 64'(b32.out_rd), 64'd5);
    chk("lw_rs1", 64'(b32.out_rs1), 64'd2);
    chk("lw_imm", 64'(b32.out_imm), 64'hFFFFFFFC);
    chk("lw_pc", 64'(b32.out_pc), 64'h100);
    chk("lw_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFC);

    // sw x5,8(x2)
    drive(1'b1, 32'h00512423, 32'h104);
    tick();
    chk("sw_fmt", 64'(b32.out_fmt), 64'd2);
    chk("sw_rs1", 64'(b32.out_rs1), 64'd2);
    chk("sw_rs2", 64'(b32.out_rs2), 64'd5);
    chk("sw_imm", 64'(b32.out_imm), 64'h8);
    chk("sw_pc", 64'(b32.out_pc), 64'h104);

    // Branch with negative offset
    drive(1'b1, 32'hFE000CE3, 32'h108);
    tick();
    chk("b_fmt", 64'(b32.out_fmt), 64'd3);
    chk("b_imm", 64'(b32.out_imm), 64'hFFFFFFF8);
    chk("b_imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFF8);

    // lui x1,0x12345
    drive(1'b1, 32'h123450B7, 32'h10C);
    tick();
    chk("u_fmt", 64'(b32.out_fmt), 64'd4);
    chk("u_rd", 64'(b32.out_rd), 64'd1);
    chk("u_imm", 64'(b32.out_imm), 64'h12345000);

    // jal x1,+0x800
    drive(1'b1, 32'h001000EF, 32'h110);
    tick();
    chk("j_fmt", 64'(b32.out_fmt), 64'd5);
    chk("j_rd", 64'(b32.out_rd), 64'd1);
    chk("j_imm", 64'(b32.out_imm), 64'h800);

    // sub x10,x10,x11
    drive(1'b1, 32'h40B50533, 32'h114);
    tick();
    chk("r_fmt", 64'(b32.out_fmt), 64'd0);
    chk("r_imm", 64'(b32.out_imm), 64'd0);
    chk("r_rd", 64'(b32.out_rd), 64'd10);
    chk("r_rs1", 64'(b32.out_rs1), 64'd10);
    chk("r_rs2", 64'(b32.out_rs2), 64'd11);
    chk("r_f7", 64'(b32.out_funct7), 64'h20);
    chk("r_f3", 64'(b32.out_funct3), 64'd0);

    // Unknown opcode
    drive(1'b1, 32'h0000007F, 32'h118);
    tick();
    chk("ill_fmt", 64'(b32.out_fmt), 64'd7);
    chk("ill_flag", 64'(b32.out_illegal), 64'd1);
    chk("ill_imm", 64'(b32.out_imm), 64'd0);

    // Low bits not 11 (otherwise addi-like)
    drive(1'b1, 32'h00100010, 32'h11C);
    tick();
    chk("c16_fmt", 64'(b32.out_fmt), 64'd7);
    chk("c16_flag", 64'(b32.out_illegal), 64'd1);

    // Idle: output drains
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("idle_valid", 64'(b32.out_valid), 64'd0);

    // Back-pressure: A, B held, C stalled
    b32.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200);
    tick();
    chk("bp_a_valid", 64'(b32.out_valid), 64'd1);
    chk("bp_a_imm", 64'(b32.out_imm), 64'd1);
    chk("bp_a_ready", 64'(b32.in_ready), 64'd1);
    drive(1'b1, 32'h00200113, 32'h204);
    tick();
    chk("bp_b_ready", 64'(b32.in_ready), 64'd0);
    chk("bp_b_hold", 64'(b32.out_imm), 64'd1);
    drive(1'b1, 32'h00300193, 32'h208);
    tick();
    chk("bp_c_hold_imm", 64'(b32.out_imm), 64'd1);
    chk("bp_c_hold_pc", 64'(b32.out_pc), 64'h200);
    chk("bp_c_ready", 64'(b32.in_ready), 64'd0);
    b32.out_ready = 1'b1;
    tick();
    chk("bp_out_b", 64'(b32.out_imm), 64'd2);
    chk("bp_out_b_rd", 64'(b32.out_rd), 64'd2);
    chk("bp_out_b_ready", 64'(b32.in_ready), 64'd1);
    tick();
    chk("bp_out_c", 64'(b32.out_imm), 64'd3);
    chk("bp_out_c_pc", 64'(b32.out_pc), 64'h208);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_empty", 64'(b32.out_valid), 64'd0);

    // Flush with both registers full, D presented
    b32.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h300);
    tick();
    drive(1'b1, 32'h00200113, 32'h304);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00400213, 32'h308);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    tick();
    chk("fl_no_d", 64'(b32.out_valid), 64'd0);

    // Flush with only OR full: accepted input still dropped
    drive(1'b1, 32'h00500293, 32'h310);
    b32.out_ready = 1'b0;
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00600313, 32'h314);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl2_valid", 64'(b32.out_valid), 64'd0);
    b32.out_ready = 1'b1;
    tick();
    chk("fl2_no_e", 64'(b32.out_valid), 64'd0);

    // Reset mid-stream with OR and SR full
    b32.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h400);
    tick();
    drive(1'b1, 32'h00200113, 32'h404);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 64'(b32.out_valid), 64'd0);
    chk("mrst_ready", 64'(b32.in_ready), 64'd1);
    chk("mrst_imm", 64'(b32.out_imm), 64'd0);
    chk("mrst_pc", 64'(b32.out_pc), 64'd0);
    chk("mrst_rd", 64'(b32.out_rd), 64'd0);
    b32.out_ready = 1'b1;
    drive(1'b1, 32'h00700393, 32'h500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("mrst_f_valid", 64'(b32.out_valid), 64'd1);
    chk("mrst_f_imm", 64'(b32.out_imm), 64'd7);
    chk("mrst_f_pc", 64'(b32.out_pc), 64'h500);
    tick();
    chk("mrst_f_once", 64'(b32.out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
